// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with a start/busy/done handshake and a fixed WIDTH+1 cycle latency.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem_fix, fin_result;

  // Operand decode at accept time: magnitudes plus a single result-sign flag.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & op_a[WIDTH-1];
    b_neg    = b_signed & op_b[WIDTH-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    res_neg  = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc low half holds
  // the dividend being shifted out MSB first and the quotient being shifted in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    div_diff = {rem_q, acc_q[WIDTH-1]} - {2'b00, b_mag_q};
  end

  // Signed overflow (MIN / -1) yields MIN quotient and zero remainder naturally; only a zero
  // divisor needs an explicit override, as the remainder path already returns op_a.
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    case (op_q)
      3'b000:                 fin_result = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_result = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_result = div0_q ? '1 : quo;
      default:                fin_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = funct3;
          b_mag_d = b_mag;
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          rem_d   = '0;
          neg_d   = res_neg;
          div0_d  = (op_b == '0);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          rem_d = div_diff[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : div_diff[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
      end
      StFin: begin
        result_d = fin_result;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: reset, multiply/divide results, special cases, latency and
// handshake behaviour, each checked inline against hand-computed values.
module tb_mdu_iterative;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int done_cnt = 0;

  mdu_iterative #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Issue one operation from #1 after an edge; scramble inputs after accept. poke>=0 pulses a
  // competing start (MUL 3*4) in that cycle of the operation.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output logic [31:0] res, output int lat,
                        output int bcnt);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = 32'hA5A5_5A5A; op_b = 32'h0F0F_F0F0; funct3 = 3'b111;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == poke) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result got=%h exp=00000000", result);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul();
    logic [2:0]  fs[4];
    logic [31:0] ex[4];
    logic [31:0] res;
    int lat, bc;
    fs = '{3'b000, 3'b001, 3'b011, 3'b010};
    ex = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, res, lat, bc);
      checks += 4;
      if (res !== ex[i]) begin
        errors++; $display("FAIL mul_f%0d got=%h exp=%h", fs[i], res, ex[i]);
      end
      if (lat != 33) begin errors++; $display("FAIL mul_lat_f%0d got=%0d exp=33", fs[i], lat); end
      if (bc != 33) begin errors++; $display("FAIL mul_busy_f%0d got=%0d exp=33", fs[i], bc); end
      if (busy !== 1'b0) begin
        errors++; $display("FAIL mul_busy_in_done_f%0d got=%b exp=0", fs[i], busy);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fs[4];
    logic [31:0] as[4], bs[4], ex[4];
    logic [31:0] res;
    int lat, bc;
    fs = '{3'b100, 3'b110, 3'b101, 3'b111};
    as = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    bs = '{32'd2, 32'd2, 32'd7, 32'd7};
    ex = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], as[i], bs[i], -1, res, lat, bc);
      checks += 2;
      if (res !== ex[i]) begin
        errors++; $display("FAIL div_f%0d a=%h b=%h got=%h exp=%h", fs[i], as[i], bs[i], res, ex[i]);
      end
      if (lat != 33) begin errors++; $display("FAIL div_lat_f%0d got=%0d exp=33", fs[i], lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs[7];
    logic [31:0] as[7], bs[7], ex[7];
    logic [31:0] res;
    int lat, bc;
    fs = '{3'b101, 3'b111, 3'b100, 3'b100, 3'b110, 3'b100, 3'b110};
    as = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    bs = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    ex = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF,
           32'hFFFF_FFFB};
    for (int i = 0; i < 7; i++) begin
      run_op(fs[i], as[i], bs[i], -1, res, lat, bc);
      checks += 2;
      if (res !== ex[i]) begin
        errors++;
        $display("FAIL special%0d f=%0d a=%h b=%h got=%h exp=%h", i, fs[i], as[i], bs[i], res,
                 ex[i]);
      end
      if (lat != 33) begin errors++; $display("FAIL special_lat%0d got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] res;
    int lat, bc;
    run_op(3'b101, 32'd100, 32'd7, 5, res, lat, bc);
    checks += 2;
    if (res !== 32'd14) begin errors++; $display("FAIL ignored_res got=%0d exp=14", res); end
    if (lat != 33) begin errors++; $display("FAIL ignored_lat got=%0d exp=33", lat); end
    @(posedge clk); #1;
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL ignored_done_after got=%b exp=0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy_after got=%b exp=0", busy); end
    if (result !== 32'd14) begin
      errors++; $display("FAIL ignored_hold got=%0d exp=14", result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2, b1, b2;
    int unsigned t1, t2;
    run_op(3'b101, 32'd9, 32'd3, -1, r1, l1, b1);
    t1 = cyc;
    checks += 2;
    if (r1 !== 32'd3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", r1); end
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    run_op(3'b000, 32'd3, 32'd4, -1, r2, l2, b2);
    t2 = cyc;
    checks += 3;
    if (r2 !== 32'd12) begin errors++; $display("FAIL b2b_second got=%0d exp=12", r2); end
    if (l2 != 33) begin errors++; $display("FAIL b2b_lat got=%0d exp=33", l2); end
    if (t2 - t1 != 34) begin errors++; $display("FAIL b2b_gap got=%0d exp=34", t2 - t1); end
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", done); end
    if (result !== 32'd12) begin errors++; $display("FAIL b2b_hold got=%0d exp=12", result); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat, bc, dc;
    run_op(3'b000, 32'd6, 32'd7, -1, res, lat, bc);
    checks++;
    if (res !== 32'd42) begin errors++; $display("FAIL abort_pre got=%0d exp=42", res); end
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    dc = done_cnt;
    reset = 1'b1;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    if (result !== 32'h0) begin errors++; $display("FAIL abort_result got=%h exp=0", result); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks += 2;
    if (done_cnt != dc) begin
      errors++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, dc);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
    run_op(3'b000, 32'd3, 32'd4, -1, res, lat, bc);
    checks += 2;
    if (res !== 32'd12) begin errors++; $display("FAIL abort_after got=%0d exp=12", res); end
    if (lat != 33) begin errors++; $display("FAIL abort_after_lat got=%0d exp=33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
